// File: rtl/simon_blinker.sv
// Simon Says pattern playback: plays stored colours 0..level-1 on one-hot LEDs, then pulses blinker_done.
// Optional SIMON_BLINK_SPEEDUP_EN shortens the lit time at higher levels.
module simon_blinker #(
  parameter int ON_CYCLES  = 25_000_000,
  parameter int OFF_CYCLES = 12_500_000,
  parameter int MAX_LEVEL  = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       on_blinker,
  input  logic [3:0] level,
  output logic [3:0] mem_addr,
  input  logic [1:0] mem_data,
  output logic [3:0] led,
  output logic       blinker_done
);

  localparam int MAX_CYC = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
  localparam int TW      = (MAX_CYC < 2) ? 1 : $clog2(MAX_CYC + 1);
  localparam logic [TW-1:0] OFF_LOAD = TW'(OFF_CYCLES - 1);
  localparam logic [3:0]    MAX_LVL  = 4'(MAX_LEVEL);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_ON, S_OFF, S_DONE, S_WAIT_LOW
  } state_t;

  state_t        state_q;
  logic [3:0]    lvl_q, step_q, addr_q, led_q;
  logic [TW-1:0] timer_q, on_load_q;
  logic          fetch_q, done_q;
  logic [3:0]    lvl_d;
  logic [TW-1:0] on_len_d;

  always_comb begin
    lvl_d = (level > MAX_LVL) ? MAX_LVL : level;
`ifdef SIMON_BLINK_SPEEDUP_EN
    if (lvl_d >= 4'd8)      on_len_d = TW'(ON_CYCLES >> 2);
    else if (lvl_d >= 4'd4) on_len_d = TW'(ON_CYCLES >> 1);
    else                    on_len_d = TW'(ON_CYCLES);
    if (on_len_d == '0)     on_len_d = TW'(1);
`else
    on_len_d = TW'(ON_CYCLES);
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      lvl_q     <= '0;
      step_q    <= '0;
      addr_q    <= '0;
      led_q     <= '0;
      timer_q   <= '0;
      on_load_q <= '0;
      fetch_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          led_q  <= '0;
          done_q <= 1'b0;
          if (on_blinker) begin
            lvl_q     <= lvl_d;
            on_load_q <= on_len_d - TW'(1);
            step_q    <= '0;
            addr_q    <= '0;
            fetch_q   <= 1'b0;
            if (lvl_d == 4'd0) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_FETCH;
            end
          end
        end
        S_FETCH: begin
          if (!on_blinker) begin
            state_q <= S_IDLE;
            led_q   <= '0;
            fetch_q <= 1'b0;
          end else if (!fetch_q) begin
            fetch_q <= 1'b1;
          end else begin
            // Memory data for addr_q is valid in this second fetch cycle.
            fetch_q <= 1'b0;
            led_q   <= 4'd1 << mem_data;
            timer_q <= on_load_q;
            state_q <= S_ON;
          end
        end
        S_ON: begin
          if (!on_blinker) begin
            state_q <= S_IDLE;
            led_q   <= '0;
          end else if (timer_q == '0) begin
            led_q   <= '0;
            timer_q <= OFF_LOAD;
            state_q <= S_OFF;
          end else begin
            timer_q <= timer_q - TW'(1);
          end
        end
        S_OFF: begin
          if (!on_blinker) begin
            state_q <= S_IDLE;
            led_q   <= '0;
          end else if (timer_q == '0) begin
            step_q <= step_q + 4'd1;
            if (step_q + 4'd1 == lvl_q) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              addr_q  <= step_q + 4'd1;
              state_q <= S_FETCH;
            end
          end else begin
            timer_q <= timer_q - TW'(1);
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          state_q <= S_WAIT_LOW;
        end
        S_WAIT_LOW: begin
          if (!on_blinker) state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
          led_q   <= '0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign mem_addr     = addr_q;
  assign led          = led_q;
  assign blinker_done = done_q;

endmodule

// File: tb/tb_simon_blinker.sv
// Directed bench for simon_blinker: per-cycle expected LED/done/address pushed to a queue, popped on negedges.
module tb_simon_blinker;
  localparam int ON  = 4;
  localparam int OFF = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       on_blinker = 1'b0;
  logic [3:0] level = 4'd0;
  logic [3:0] mem_addr;
  logic [1:0] mem_data = 2'd0;
  logic [3:0] led;
  logic       blinker_done;

  logic [1:0] mem [16];

  typedef struct {
    string      tag;
    logic [3:0] led;
    logic       done;
    logic [3:0] addr;
    bit         chk_addr;
  } exp_t;
  exp_t q[$];

  int checks = 0;
  int errors = 0;

  simon_blinker #(.ON_CYCLES(ON), .OFF_CYCLES(OFF), .MAX_LEVEL(10)) dut (
    .clk(clk), .reset(reset), .on_blinker(on_blinker), .level(level),
    .mem_addr(mem_addr), .mem_data(mem_data), .led(led), .blinker_done(blinker_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) mem_data <= mem[mem_addr];

  initial begin
    #200000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  function automatic int on_len(input int lvl);
`ifdef SIMON_BLINK_SPEEDUP_EN
    int v;
    v = (lvl >= 8) ? (ON >> 2) : (lvl >= 4) ? (ON >> 1) : ON;
    return (v < 1) ? 1 : v;
`else
    return ON;
`endif
  endfunction

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  // Expected trace from cycle S; ncyc<0 means full play plus WAIT_LOW tail.
  task automatic push_play(input int req_level, input int ncyc);
    int lvl, onl, p, last, k, r;
    exp_t e;
    lvl  = (req_level > 10) ? 10 : req_level;
    onl  = on_len(lvl);
    p    = 2 + onl + OFF;
    last = (ncyc < 0) ? lvl * p : ncyc - 1;
    for (int c = 0; c <= last; c++) begin
      k = c / p;
      r = c % p;
      e.tag      = $sformatf("lvl%0d_S+%0d", req_level, c);
      e.led      = 4'd0;
      e.done     = (c == lvl * p);
      e.addr     = 4'(k);
      e.chk_addr = (lvl == 0) || (c < lvl * p && r < 2);
      if (c < lvl * p && r >= 2 && r < 2 + onl) e.led = 4'd1 << mem[k];
      q.push_back(e);
    end
    if (ncyc < 0) begin
      for (int c = 1; c <= 3; c++) begin
        e.tag = $sformatf("lvl%0d_waitlow%0d", req_level, c);
        e.led = 4'd0; e.done = 1'b0; e.addr = 4'd0; e.chk_addr = 1'b0;
        q.push_back(e);
      end
    end
  endtask

  task automatic push_quiet(input string tag, input int n);
    exp_t e;
    for (int c = 0; c < n; c++) begin
      e.tag = $sformatf("%s%0d", tag, c);
      e.led = 4'd0; e.done = 1'b0; e.addr = 4'd0; e.chk_addr = 1'b0;
      q.push_back(e);
    end
  endtask

  task automatic run_queue();
    exp_t e;
    while (q.size() > 0) begin
      @(negedge clk);
      e = q.pop_front();
      check({e.tag, "_led"}, led, e.led);
      check({e.tag, "_done"}, {3'd0, blinker_done}, {3'd0, e.done});
      if (e.chk_addr) check({e.tag, "_addr"}, mem_addr, e.addr);
    end
  endtask

  task automatic start(input logic [3:0] lv);
    @(negedge clk);
    level = lv;
    on_blinker = 1'b1;
    @(posedge clk);
  endtask

  task automatic finish_play();
    @(negedge clk);
    on_blinker = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 2'(i % 4);
    repeat (3) @(posedge clk);
    #1;
    check("reset_led", led, 4'd0);
    check("reset_done", {3'd0, blinker_done}, 4'd0);
    check("reset_addr", mem_addr, 4'd0);
    @(negedge clk);
    reset = 1'b0;

    // Level 0: immediate done, nothing lit.
    start(4'd0);
    push_play(0, -1);
    run_queue();
    finish_play();

    // Level 1, colour 2.
    mem[0] = 2'd2;
    start(4'd1);
    push_play(1, -1);
    run_queue();
    finish_play();

    // Level 3, colours 0,3,1; level input changes mid-play are ignored.
    mem[0] = 2'd0; mem[1] = 2'd3; mem[2] = 2'd1;
    start(4'd3);
    #1 level = 4'd15;
    push_play(3, -1);
    run_queue();
    finish_play();

    // Level 4: ON duration depends on speedup build.
    mem[3] = 2'd2;
    start(4'd4);
    push_play(4, -1);
    run_queue();
    finish_play();

    // Level 12 clamps to 10 steps; held request gives no second pulse.
    for (int i = 0; i < 16; i++) mem[i] = 2'((i * 3 + 1) % 4);
    start(4'd12);
    push_play(12, -1);
    push_quiet("lvl12_hold", 4);
    run_queue();
    finish_play();

    // Abort in step 0 at S+4.
    mem[0] = 2'd1;
    start(4'd2);
    push_play(2, 5);
    run_queue();
    on_blinker = 1'b0;
    push_quiet("abort_idle", 5);
    run_queue();

    // Asynchronous reset mid-ON.
    mem[0] = 2'd3;
    start(4'd1);
    push_play(1, 4);
    run_queue();
    #2 reset = 1'b1;
    #1;
    check("midreset_led", led, 4'd0);
    check("midreset_done", {3'd0, blinker_done}, 4'd0);
    check("midreset_addr", mem_addr, 4'd0);
    @(negedge clk);
    on_blinker = 1'b0;
    reset = 1'b0;

    // Block is usable again after reset.
    mem[0] = 2'd2;
    start(4'd1);
    push_play(1, -1);
    run_queue();
    finish_play();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
